// File: rtl/mem_responder.sv
// Memory-side end of the 2-bit serial memory protocol: receives command frames,
// runs them on a req/ready memory port and serializes read data back as a reply.
//   state  | meaning
//   R_IDLE | waiting for a non-zero start chunk
//   R_HDR  | header cycle carries the command
//   R_PAY  | shifting in payload chunks, LSB first
//   E_IDLE | waiting for a pending entry
//   E_MEM  | memory request outstanding
//   E_SBS  | reply start chunk (2'b01)
//   E_DATA | reply data chunks, LSB first
module mem_responder #(
    parameter int NSHIFT   = 2,
    parameter int REG_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSHIFT-1:0] in_pins,
    output logic [NSHIFT-1:0] out_pins,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              overrun,
    output logic              bad_cmd
);
    localparam int WORD_BITS      = 2 * REG_BITS;
    localparam int PAYLOAD_CYCLES = WORD_BITS / NSHIFT;
    localparam logic [2:0] LAST_CHUNK = 3'(PAYLOAD_CYCLES - 1);
    localparam logic [1:0] CMD_READ16   = 2'd0;
    localparam logic [1:0] CMD_WRITE8   = 2'd1;
    localparam logic [1:0] CMD_RESERVED = 2'd3;

    typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY} rx_state_t;
    typedef enum logic [1:0] {E_IDLE, E_MEM, E_SBS, E_DATA} ex_state_t;

    rx_state_t r_state, r_next;
    ex_state_t e_state, e_next;

    logic [2:0]                  r_cnt;
    logic [1:0]                  r_cmd;
    logic [WORD_BITS-NSHIFT-1:0] r_shift;
    logic [WORD_BITS-1:0]        frame_word;
    logic                        frame_done;

    logic                 pend_valid;
    logic [1:0]           pend_cmd;
    logic [WORD_BITS-1:0] pend_word;
    logic                 take;

    logic [15:0] last_addr;
    logic [15:0] rd_shift;
    logic [2:0]  e_cnt;

    // ---------------- receiver ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next     = r_state;
        frame_done = 1'b0;
        case (r_state)
            R_IDLE: if (in_pins != '0) r_next = R_HDR;
            R_HDR:  r_next = R_PAY;
            R_PAY: begin
                if (r_cnt == LAST_CHUNK) begin
                    r_next     = R_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == R_HDR) begin
                r_cmd <= in_pins;
                r_cnt <= '0;
            end
            if (r_state == R_PAY) begin
                r_shift <= {in_pins, r_shift[WORD_BITS-NSHIFT-1:NSHIFT]};
                r_cnt   <= r_cnt + 3'd1;
            end
        end
    end

    // The last chunk is still on the pins when the frame completes.
    assign frame_word = {in_pins, r_shift};

    // ---------------- pending entry ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_cmd   <= '0;
            pend_word  <= '0;
            overrun    <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            if (take) pend_valid <= 1'b0;
            if (frame_done) begin
                if (r_cmd == CMD_RESERVED) begin
                    bad_cmd <= 1'b1;
                end else if (pend_valid && !take) begin
                    overrun <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_cmd   <= r_cmd;
                    pend_word  <= frame_word;
                end
            end
        end
    end

    // ---------------- executor ----------------
    assign take = (e_state == E_IDLE) && pend_valid;

    always_ff @(posedge clk) begin
        if (reset) e_state <= E_IDLE;
        else       e_state <= e_next;
    end

    always_comb begin
        e_next = e_state;
        case (e_state)
            E_IDLE: if (pend_valid) e_next = E_MEM;
            E_MEM:  if (mem_ready) e_next = mem_we ? E_IDLE : E_SBS;
            E_SBS:  e_next = E_DATA;
            E_DATA: if (e_cnt == LAST_CHUNK) e_next = E_IDLE;
            default: e_next = E_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            last_addr <= '0;
            rd_shift  <= '0;
            e_cnt     <= '0;
        end else begin
            if (take) begin
                case (pend_cmd)
                    CMD_READ16: begin
                        mem_we    <= 1'b0;
                        mem_addr  <= pend_word;
                        mem_wmask <= 2'b00;
                        last_addr <= pend_word;
                    end
                    CMD_WRITE8: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= last_addr;
                        mem_wdata <= {2{pend_word[REG_BITS-1:0]}};
                        mem_wmask <= last_addr[0] ? 2'b10 : 2'b01;
                    end
                    default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= last_addr;
                        mem_wdata <= pend_word;
                        mem_wmask <= 2'b11;
                    end
                endcase
            end
            if (e_state == E_MEM && mem_ready && !mem_we) rd_shift <= mem_rdata;
            if (e_state == E_SBS) e_cnt <= '0;
            if (e_state == E_DATA) begin
                rd_shift <= {2'b00, rd_shift[15:2]};
                e_cnt    <= e_cnt + 3'd1;
            end
        end
    end

    assign mem_req = (e_state == E_MEM);

    always_comb begin
        out_pins = '0;
        case (e_state)
            E_SBS:   out_pins = NSHIFT'(1);
            E_DATA:  out_pins = rd_shift[NSHIFT-1:0];
            default: out_pins = '0;
        endcase
    end

    assign busy = (r_state != R_IDLE) || pend_valid || (e_state != E_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized frames, checked every
// cycle against a transaction-level model built from queues.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_pins;
    logic [1:0]  out_pins;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_wmask;
    logic        busy, overrun, bad_cmd;

    mem_responder dut (
        .clk(clk), .reset(reset), .in_pins(in_pins), .out_pins(out_pins),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .busy(busy), .overrun(overrun), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rises = 0;
    logic prev_req = 1'b0;

    // driver-side knowledge of frame structure, handed to the model
    bit          drv_rxb = 1'b0;
    bit          drv_fe  = 1'b0;
    logic [1:0]  drv_cmd = 2'd0;
    logic [15:0] drv_word = 16'd0;
    int          rdy_mode = 0;
    bit          rdata_fix = 1'b0;
    logic [15:0] rdata_val = 16'd0;

    // model state
    bit          m_pv = 1'b0, m_req = 1'b0, m_we = 1'b0, m_ovr = 1'b0, m_bad = 1'b0;
    logic [1:0]  m_pcmd = 2'd0, m_wmask = 2'd0;
    logic [15:0] m_pword = 16'd0, m_addr = 16'd0, m_wdata = 16'd0, m_last = 16'd0;
    logic [1:0]  m_reply[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_req === 1'b1 && prev_req !== 1'b1) n_rises++;
        prev_req = mem_req;
    end

    // compare, then advance the model across the coming edge
    always @(negedge clk) begin : model
        bit take;
        if (cyc >= 2) begin
            chk("mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_we", 32'(mem_we), 32'(m_we));
                if (m_we) begin
                    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                    chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
                end
            end
            chk("out_pins", 32'(out_pins), (m_reply.size() != 0) ? 32'(m_reply[0]) : 32'd0);
            chk("busy", 32'(busy), 32'(drv_rxb || m_pv || m_req || (m_reply.size() != 0)));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("bad_cmd", 32'(bad_cmd), 32'(m_bad));
        end
        if (reset) begin
            m_pv = 0; m_req = 0; m_we = 0; m_ovr = 0; m_bad = 0;
            m_addr = 0; m_wdata = 0; m_wmask = 0; m_last = 0;
            m_reply.delete();
        end else begin
            take = !m_req && (m_reply.size() == 0) && m_pv;
            if (m_reply.size() != 0) void'(m_reply.pop_front());
            if (m_req && mem_ready) begin
                m_req = 0;
                if (!m_we) begin
                    m_reply.push_back(2'b01);
                    for (int i = 0; i < 8; i++) m_reply.push_back(mem_rdata[2*i +: 2]);
                end
            end
            if (take) begin
                m_pv = 0;
                m_req = 1;
                if (m_pcmd == 2'd0) begin
                    m_we = 0; m_addr = m_pword; m_last = m_pword;
                end else if (m_pcmd == 2'd1) begin
                    m_we = 1; m_addr = m_last; m_wdata = {m_pword[7:0], m_pword[7:0]};
                    m_wmask = m_last[0] ? 2'b10 : 2'b01;
                end else begin
                    m_we = 1; m_addr = m_last; m_wdata = m_pword; m_wmask = 2'b11;
                end
            end
            if (drv_fe) begin
                if (drv_cmd == 2'd3) m_bad = 1;
                else if (m_pv) m_ovr = 1;
                else begin
                    m_pv = 1; m_pcmd = drv_cmd; m_pword = drv_word;
                end
            end
        end
    end

    task automatic step(input logic [1:0] pins, input bit rxb, input bit rst);
        @(posedge clk);
        #1;
        in_pins   = pins;
        reset     = rst;
        drv_rxb   = rxb;
        drv_fe    = 1'b0;
        mem_ready = (rdy_mode == 0) || (rdy_mode == 1 && $urandom_range(0, 2) != 0);
        mem_rdata = rdata_fix ? rdata_val : 16'($urandom);
    endtask

    task automatic send_frame(input logic [1:0] cmd, input logic [15:0] word);
        step(2'($urandom_range(1, 3)), 1'b0, 1'b0);
        step(cmd, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(word[2*i +: 2], 1'b1, 1'b0);
        drv_fe   = 1'b1;
        drv_cmd  = cmd;
        drv_word = word;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step(2'b00, 1'b0, 1'b0);
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        chk("idle_timeout", 32'(done), 32'd1);
    endtask

    initial begin : watchdog
        #300000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : main
        int exp_seq[8];
        int base;
        int r;
        logic [1:0] cmd;
        exp_seq = '{3, 3, 2, 3, 2, 3, 3, 2};
        reset = 1'b1; in_pins = 2'b00; mem_ready = 1'b0; mem_rdata = 16'd0;

        repeat (3) step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_out", 32'(out_pins), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_flags", 32'({mem_we, overrun, bad_cmd}), 32'd0);

        // read, zero-wait
        rdy_mode = 0; rdata_fix = 1'b1; rdata_val = 16'hBEEF;
        send_frame(2'd0, 16'h1234);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_req", 32'(mem_req), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'h1234);
        chk("rd_we", 32'(mem_we), 32'd0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_req_once", 32'(mem_req), 32'd0);
        chk("rd_sbs", 32'(out_pins), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(2'b00, 1'b0, 1'b0);
            @(negedge clk);
            chk("rd_data", 32'(out_pins), 32'(exp_seq[i]));
        end
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_end", 32'(out_pins), 32'd0);
        rdata_fix = 1'b0;
        wait_idle();

        // byte and word writes land on the last read address
        send_frame(2'd0, 16'h0101);
        wait_idle();
        send_frame(2'd1, 16'h00A5);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("wr8_addr", 32'(mem_addr), 32'h0101);
        chk("wr8_mask", 32'(mem_wmask), 32'd2);
        chk("wr8_wdata", 32'(mem_wdata), 32'hA5A5);
        chk("wr8_we", 32'(mem_we), 32'd1);
        wait_idle();
        send_frame(2'd2, 16'hCAFE);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("wr16_addr", 32'(mem_addr), 32'h0101);
        chk("wr16_mask", 32'(mem_wmask), 32'd3);
        chk("wr16_wdata", 32'(mem_wdata), 32'hCAFE);
        wait_idle();

        // wait states: ready low T+11..T+15, reply start at T+17
        rdy_mode = 2;
        send_frame(2'd0, 16'h4321);
        step(2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(2'b00, 1'b0, 1'b0);
            @(negedge clk);
            chk("ws_req", 32'(mem_req), 32'd1);
            chk("ws_addr", 32'(mem_addr), 32'h4321);
        end
        rdy_mode = 0;
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("ws_req_last", 32'(mem_req), 32'd1);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("ws_sbs", 32'(out_pins), 32'd1);
        wait_idle();

        // overrun: three back-to-back reads against a stalled memory
        base = n_rises;
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) send_frame(2'd0, 16'($urandom));
        repeat (12) step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_flag", 32'(overrun), 32'd1);
        rdy_mode = 0;
        wait_idle();
        chk("ovr_reqs", 32'(n_rises - base), 32'd2);

        // reserved header
        base = n_rises;
        send_frame(2'd3, 16'($urandom));
        repeat (4) step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("bad_flag", 32'(bad_cmd), 32'd1);
        chk("bad_noreq", 32'(n_rises - base), 32'd0);
        send_frame(2'd0, 16'($urandom));
        wait_idle();
        chk("bad_then_read", 32'(n_rises - base), 32'd1);

        // reset in reply data cycle 4, then a write goes to address 0
        send_frame(2'd0, 16'h5555);
        step(2'b00, 1'b0, 1'b0);
        repeat (5) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_mid_out", 32'(out_pins), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        send_frame(2'd2, 16'h9999);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_wr_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr_req", 32'(mem_req), 32'd1);
        wait_idle();

        // randomized traffic with random ready and occasional resets
        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            cmd = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 15) == 0) step(2'b00, 1'b0, 1'b1);
            repeat ($urandom_range(0, 4)) step(2'b00, 1'b0, 1'b0);
            send_frame(cmd, 16'($urandom));
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side end of the CPU's 2-bit serial memory protocol. It deserializes command frames sent by the CPU scheduler (READ_16, WRITE_8, WRITE_16) and performs the access on a parallel req/ready memory port. For reads, it serializes the 16-bit read data back to the CPU as an RX reply frame. It sits between the CPU's TX/RX pins and the RAM or peripheral bus.

## Interface
- `NSHIFT`, default 2: bits per serial cycle. Only the default is supported.
- `REG_BITS`, default 8: byte width. Word = 2*REG_BITS = 16 bits; `PAYLOAD_CYCLES` = 2*REG_BITS/NSHIFT = 8.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_pins`  in  NSHIFT  command stream from CPU; idle = 0.
- `out_pins`  out  NSHIFT  reply stream to CPU; idle = 0.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  16  byte address.
- `mem_wdata`  out  16  write data.
- `mem_wmask`  out  2  byte enables, bit0 = low byte.
- `mem_ready`  in  1  request completes in the cycle where `mem_req && mem_ready`.
- `mem_rdata`  in  16  read data; sampled in the completing cycle.
- `busy`  out  1  receiver not in R_IDLE, or pending valid, or executor not in E_IDLE.
- `overrun`  out  1  sticky: a frame was dropped because pending was full.
- `bad_cmd`  out  1  sticky: a frame with reserved header 3 was received.

## Operation
- **Command frame:** 10 cycles.
  - Start cycle: any `in_pins` != 0 while the receiver is in R_IDLE.
  - Header cycle: 0 = READ_16, 1 = WRITE_8, 2 = WRITE_16, 3 = reserved.
  - 8 payload cycles, LSB chunk first.
  - READ_16 payload = address. Write payload = data; WRITE_8 uses payload[7:0] only.
- **Receiver FSM:** R_IDLE → R_HDR → R_PAY (3-bit counter 0..7) → R_IDLE.
  - During R_HDR/R_PAY, `in_pins` value is data only and does not restart a frame.
  - A new start may arrive in the cycle right after the last payload cycle.
- **Pending register:** one entry {cmd, word}, loaded at the end of the frame.
  - If pending is still valid at load time and is not being taken on the same edge: the frame is dropped and `overrun` sets.
  - Reserved-header frames are consumed, never loaded, and set `bad_cmd`.
- **Executor FSM:** E_IDLE → E_MEM → (reads) E_SBS → E_DATA (8 cycles) → E_IDLE; (writes) E_MEM → E_IDLE.
  - E_IDLE with pending valid: take the entry and clear pending.
  - READ_16: `last_addr` ← word; `mem_addr` = word; `mem_we` = 0.
  - WRITE_16: `mem_addr` = `last_addr`; `mem_wdata` = word; `mem_wmask` = 2'b11.
  - WRITE_8: `mem_addr` = `last_addr`; `mem_wdata` = {word[7:0], word[7:0]}; `mem_wmask` = `last_addr[0]` ? 2'b10 : 2'b01.
  - `last_addr` is never incremented. Writes always target the most recent read address; this is 0 after reset.
- **Reply frame:** 9 cycles.
  - E_SBS: `out_pins` = 2'b01.
  - E_DATA: captured read data, 2 bits per cycle, LSB first.
  - `out_pins` = 0 in all other states.
- Receiving continues independently while the executor is busy.

## Timing
- Start sampled in cycle T. Header in T+1, payload T+2..T+9, pending valid in T+10.
- Executor takes the entry at the end of T+10; `mem_req` is high from T+11.
- Zero-wait memory (`mem_ready` high in T+11):
  - Read: `out_pins` = 01 in T+12, data in T+13..T+20, 0 in T+21.
  - Write: `mem_req` is low in T+12.
- Each cycle of `mem_ready` delay shifts all later events by one cycle.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wmask` are registered and stable while `mem_req` is high.
- Pending is taken and a new frame completes on the same edge: the new frame loads, no overrun.
- **Reset** (any time, including mid-frame, mid-request or mid-reply), effective the next cycle:
  - Outputs: `out_pins` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr`/`mem_wdata` = 0, `mem_wmask` = 0, `busy` = 0, `overrun` = 0, `bad_cmd` = 0.
  - State: both FSMs idle, pending cleared, `last_addr` = 0.
  - An abandoned memory request is dropped and not retried.

## Test plan
- **Read, zero-wait:** READ_16 addr 0x1234, `mem_ready` tied 1, `mem_rdata` = 0xBEEF → `mem_req` high exactly 1 cycle with `mem_addr` = 0x1234 and `mem_we` = 0. `out_pins` = 1, then 3,3,2,3,2,3,3,2, then 0.
- **Byte write after read:** READ_16 0x0101, then WRITE_8 data 0x00A5 → write with `mem_addr` = 0x0101, `mem_wmask` = 2'b10, `mem_wdata` = 0xA5A5. Repeat as WRITE_16 0xCAFE → `mem_wmask` = 11, `mem_wdata` = 0xCAFE.
- **Overrun:** three back-to-back READ_16 frames, `mem_ready` held low for 30 cycles → first frame executes, second is held in pending, third is dropped. `overrun` = 1; exactly two replies emitted, in order.
- **Reserved header:** frame with header 3 → `bad_cmd` = 1, no `mem_req`; a following READ_16 works normally.
- **Reset mid-operation:** reset asserted in reply data cycle 4 → `out_pins` = 0 and `busy` = 0 the next cycle. A subsequent WRITE_16 uses `mem_addr` = 0.
- **Wait states:** `mem_ready` delayed 5 cycles → `mem_req` and `mem_addr` held stable throughout; reply start moves to T+17.
